// File: rtl/alu_pkg.sv
// Shared opcode constants, opcode-class encodings, FSM states and flag layout
// for the ALU execute controller.
package alu_pkg;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_CMPU = 8'h0F;

    // Opcode classes by high nibble
    localparam logic [3:0] CLS_REG   = 4'b0000;
    localparam logic [3:0] CLS_ADDI  = 4'b0101;
    localparam logic [3:0] CLS_ADDUI = 4'b0110;
    localparam logic [3:0] CLS_ADDCI = 4'b0111;
    localparam logic [3:0] CLS_SUBCI = 4'b1000;
    localparam logic [3:0] CLS_SUBI  = 4'b1001;
    localparam logic [3:0] CLS_CMPI  = 4'b1011;

    localparam int FLAG_W = 5;

    // Field order gives the flag bit indices: Z=4, C=3, F=2, N=1, L=0
    typedef struct packed {
        logic z;
        logic c;
        logic f;
        logic n;
        logic l;
    } flags_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    function automatic logic is_undef_reg(input logic [3:0] lo);
        return (lo == 4'b1010) || (lo == 4'b1100) || (lo == 4'b1101) || (lo == 4'b1110);
    endfunction

endpackage

// File: rtl/alu_opmap.sv
// Combinational opcode decode: ALU opcode remap, immediate selection and
// writeback / flag-update enables.
module alu_opmap
    import alu_pkg::*;
(
    input  logic [7:0] opcode,
    output logic [7:0] alu_opcode,
    output logic       imm_sel,
    output logic       sign_ext,
    output logic       wb_en,
    output logic       flag_en
);

    always_comb begin
        alu_opcode = OP_NOP;
        imm_sel    = 1'b0;
        sign_ext   = 1'b0;
        wb_en      = 1'b0;
        flag_en    = 1'b0;
        case (opcode[3+4:4])
            CLS_REG: begin
                // Undefined register-register encodings fall through as NOP
                if (opcode != OP_NOP && !is_undef_reg(opcode[3:0])) begin
                    alu_opcode = opcode;
                    flag_en    = 1'b1;
                    wb_en      = !(opcode == OP_CMP || opcode == OP_CMPU);
                end
            end
            CLS_ADDI: begin
                alu_opcode = opcode;
                imm_sel    = 1'b1;
                sign_ext   = 1'b1;
                wb_en      = 1'b1;
                flag_en    = 1'b1;
            end
            CLS_ADDUI, CLS_ADDCI, CLS_SUBCI: begin
                alu_opcode = opcode;
                imm_sel    = 1'b1;
                wb_en      = 1'b1;
                flag_en    = 1'b1;
            end
            CLS_SUBI: begin
                alu_opcode = OP_SUB;
                imm_sel    = 1'b1;
                sign_ext   = 1'b1;
                wb_en      = 1'b1;
                flag_en    = 1'b1;
            end
            CLS_CMPI: begin
                alu_opcode = OP_CMP;
                imm_sel    = 1'b1;
                sign_ext   = 1'b1;
                flag_en    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute controller: accepts one instruction, reads the register
// file, drives the external ALU, then writes back the result and flags.
module alu_exec_ctrl
    import alu_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [7:0]         opcode,
    input  logic [RADDR_W-1:0] rdest,
    input  logic [RADDR_W-1:0] rsrc,
    input  logic [7:0]         imm,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [7:0]         alu_opcode,
    output logic               alu_cin,
    input  logic [DATA_W-1:0]  alu_c,
    input  logic [FLAG_W-1:0]  alu_flags,
    output logic [FLAG_W-1:0]  psr,
    output logic               done
);

    state_t                     state;
    flags_t                     psr_q;
    logic [7:0]                 opcode_p0;
    logic [7:0]                 imm_p0;
    logic signed [DATA_W-1:0]   result_p2;
    logic [7:0]                 map_opcode;
    logic                       imm_sel;
    logic                       sign_ext;
    logic                       wb_en;
    logic                       flag_en;
    logic                       accept;

    function automatic logic signed [DATA_W-1:0] ext_imm(input logic [7:0] v, input logic sx);
        logic signed [DATA_W-1:0] r;
        r = sx ? {{(DATA_W-8){v[7]}}, v} : {{(DATA_W-8){1'b0}}, v};
        return r;
    endfunction

    alu_opmap u_opmap (
        .opcode     (opcode_p0),
        .alu_opcode (map_opcode),
        .imm_sel    (imm_sel),
        .sign_ext   (sign_ext),
        .wb_en      (wb_en),
        .flag_en    (flag_en)
    );

    assign accept = (state == ST_IDLE) && instr_valid;

    // ---- stage p0: instruction capture ----
    always_ff @(posedge clk) begin
        if (accept) begin
            opcode_p0 <= opcode;
            imm_p0    <= imm;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            instr_ready <= 1'b1;
            rf_we       <= 1'b0;
            done        <= 1'b0;
            psr_q       <= '0;
            rf_raddr_a  <= '0;
            rf_raddr_b  <= '0;
            result_p2   <= '0;
        end else begin
            rf_we <= 1'b0;
            done  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        state       <= ST_READ;
                        instr_ready <= 1'b0;
                        rf_raddr_a  <= rdest;
                        rf_raddr_b  <= rsrc;
                    end
                end
                ST_READ: state <= ST_EXEC;
                // ---- stage p2: ALU result and flags captured ----
                ST_EXEC: begin
                    state     <= ST_WB;
                    result_p2 <= alu_c;
                    if (flag_en)
                        psr_q <= flags_t'(alu_flags);
                    rf_we     <= wb_en;
                    done      <= 1'b1;
                end
                ST_WB: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

    // ---- stage p1: register data arrives, ALU driven during EXEC ----
    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_cin    = 1'b0;
        alu_opcode = OP_NOP;
        if (state == ST_EXEC) begin
            alu_a      = rf_rdata_a;
            alu_b      = imm_sel ? ext_imm(imm_p0, sign_ext) : rf_rdata_b;
            alu_cin    = psr_q.c;
            alu_opcode = map_opcode;
        end
    end

    // rf_raddr_a keeps the latched rdest for the whole instruction
    assign rf_waddr = rf_raddr_a;
    assign rf_wdata = result_p2;
    assign psr      = psr_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed bench for alu_exec_ctrl with a register-file and ALU model.
module tb_alu_exec_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [7:0]  opcode;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [7:0]  imm;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic [15:0] rf_rdata_a;
    logic [15:0] rf_rdata_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_opcode;
    logic        alu_cin;
    logic [15:0] alu_c;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;

    logic [15:0] regs [16];
    logic        pl_we;
    logic [3:0]  pl_addr;
    logic [15:0] pl_data;
    logic [16:0] wide;

    int compared;
    int mismatched;

    alu_exec_ctrl #(.DATA_W(16), .RADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .opcode      (opcode),
        .rdest       (rdest),
        .rsrc        (rsrc),
        .imm         (imm),
        .rf_raddr_a  (rf_raddr_a),
        .rf_raddr_b  (rf_raddr_b),
        .rf_rdata_a  (rf_rdata_a),
        .rf_rdata_b  (rf_rdata_b),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_cin     (alu_cin),
        .alu_c       (alu_c),
        .alu_flags   (alu_flags),
        .psr         (psr),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: one-cycle read latency, preload port has priority
    always_ff @(posedge clk) begin
        rf_rdata_a <= regs[rf_raddr_a];
        rf_rdata_b <= regs[rf_raddr_b];
        if (pl_we)
            regs[pl_addr] <= pl_data;
        else if (rf_we)
            regs[rf_waddr] <= rf_wdata;
    end

    // ALU: subtract/compare family sets Z,N,L; everything else adds and sets Z,C,F
    always_comb begin
        alu_c     = '0;
        alu_flags = '0;
        wide      = '0;
        case (alu_opcode)
            8'h09, 8'h0B, 8'h0F: begin
                wide         = {1'b0, alu_a} - {1'b0, alu_b};
                alu_c        = wide[15:0];
                alu_flags[4] = (alu_a == alu_b);
                alu_flags[1] = ($signed(alu_a) < $signed(alu_b));
                alu_flags[0] = (alu_a < alu_b);
            end
            default: begin
                wide = {1'b0, alu_a} + {1'b0, alu_b}
                     + {16'b0, alu_cin && (alu_opcode == 8'h07 || alu_opcode[7:4] == 4'h7)};
                alu_c        = wide[15:0];
                alu_flags[4] = (wide[15:0] == 16'h0000);
                alu_flags[3] = wide[16];
                alu_flags[2] = (alu_a[15] == alu_b[15]) && (wide[15] != alu_a[15]);
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] v);
        pl_we   = 1'b1;
        pl_addr = a;
        pl_data = v;
        tick();
        pl_we   = 1'b0;
    endtask

    task automatic accept_instr(input logic [7:0] op, input logic [3:0] rd,
                                input logic [3:0] rs, input logic [7:0] im);
        instr_valid = 1'b1;
        opcode      = op;
        rdest       = rd;
        rsrc        = rs;
        imm         = im;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        compared    = 0;
        mismatched  = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        opcode      = '0;
        rdest       = '0;
        rsrc        = '0;
        imm         = '0;
        pl_we       = 1'b0;
        pl_addr     = '0;
        pl_data     = '0;
        tick();
        tick();
        reset = 1'b0;

        chk("rst_ready", 16'(instr_ready), 16'd1);
        chk("rst_we", 16'(rf_we), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_psr", 16'(psr), 16'd0);
        chk("rst_raddr_a", 16'(rf_raddr_a), 16'd0);
        chk("rst_raddr_b", 16'(rf_raddr_b), 16'd0);
        chk("rst_result", rf_wdata, 16'h0000);
        chk("rst_alu_op", 16'(alu_opcode), 16'h0000);

        // ADD R1=0x7FFF + R2=0x0001: signed overflow
        preload(4'd1, 16'h7FFF);
        preload(4'd2, 16'h0001);
        accept_instr(8'h05, 4'd1, 4'd2, 8'h00);
        chk("add_raddr_a", 16'(rf_raddr_a), 16'd1);
        chk("add_raddr_b", 16'(rf_raddr_b), 16'd2);
        chk("add_busy_ready", 16'(instr_ready), 16'd0);
        chk("add_read_alu_a", alu_a, 16'h0000);
        tick();
        chk("add_alu_a", alu_a, 16'h7FFF);
        chk("add_alu_b", alu_b, 16'h0001);
        chk("add_alu_op", 16'(alu_opcode), 16'h0005);
        chk("add_cin", 16'(alu_cin), 16'd0);
        tick();
        chk("add_we", 16'(rf_we), 16'd1);
        chk("add_waddr", 16'(rf_waddr), 16'd1);
        chk("add_wdata", rf_wdata, 16'h8000);
        chk("add_done", 16'(done), 16'd1);
        chk("add_psr", 16'(psr), 16'h0004);
        chk("add_wb_alu_op", 16'(alu_opcode), 16'h0000);
        tick();
        chk("add_r1", regs[1], 16'h8000);
        chk("add_done_low", 16'(done), 16'd0);
        chk("add_we_low", 16'(rf_we), 16'd0);
        chk("add_ready_back", 16'(instr_ready), 16'd1);

        // ADDI sign-extended imm 0xFF
        preload(4'd3, 16'h0005);
        accept_instr(8'h50, 4'd3, 4'd0, 8'hFF);
        tick();
        chk("addi_alu_a", alu_a, 16'h0005);
        chk("addi_alu_b", alu_b, 16'hFFFF);
        chk("addi_alu_op", 16'(alu_opcode), 16'h0050);
        tick();
        chk("addi_wdata", rf_wdata, 16'h0004);
        chk("addi_psr", 16'(psr), 16'h0008);
        tick();
        chk("addi_r3", regs[3], 16'h0004);

        // ADDUI zero-extended imm 0xFF
        preload(4'd14, 16'h0001);
        accept_instr(8'h61, 4'd14, 4'd0, 8'hFF);
        tick();
        chk("addui_alu_b", alu_b, 16'h00FF);
        chk("addui_alu_op", 16'(alu_opcode), 16'h0061);
        tick();
        chk("addui_wdata", rf_wdata, 16'h0100);
        chk("addui_psr", 16'(psr), 16'h0000);
        tick();

        // SUBI remapped to 0x09, imm 0xFE sign-extended
        preload(4'd15, 16'h0010);
        accept_instr(8'h9F, 4'd15, 4'd0, 8'hFE);
        tick();
        chk("subi_alu_op", 16'(alu_opcode), 16'h0009);
        chk("subi_alu_b", alu_b, 16'hFFFE);
        tick();
        chk("subi_we", 16'(rf_we), 16'd1);
        chk("subi_wdata", rf_wdata, 16'h0012);
        chk("subi_psr", 16'(psr), 16'h0001);
        tick();
        chk("subi_r15", regs[15], 16'h0012);

        // CMP: flags only, no writeback
        preload(4'd4, 16'h0003);
        preload(4'd5, 16'h0005);
        accept_instr(8'h0B, 4'd4, 4'd5, 8'h00);
        tick();
        chk("cmp_alu_op", 16'(alu_opcode), 16'h000B);
        tick();
        chk("cmp_we", 16'(rf_we), 16'd0);
        chk("cmp_done", 16'(done), 16'd1);
        chk("cmp_psr", 16'(psr), 16'h0003);
        tick();
        chk("cmp_r4", regs[4], 16'h0003);

        // Reset during EXEC aborts: no writeback, psr cleared
        preload(4'd10, 16'hFFFF);
        preload(4'd11, 16'h0001);
        accept_instr(8'h05, 4'd10, 4'd11, 8'h00);
        tick();
        chk("rx_alu_a", alu_a, 16'hFFFF);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rx_ready", 16'(instr_ready), 16'd1);
        chk("rx_we", 16'(rf_we), 16'd0);
        chk("rx_done", 16'(done), 16'd0);
        chk("rx_psr", 16'(psr), 16'h0000);
        tick();
        chk("rx_we_after", 16'(rf_we), 16'd0);
        chk("rx_r10", regs[10], 16'hFFFF);

        // ADDU 0xFFFF + 0x0001 -> 0 with carry
        preload(4'd6, 16'hFFFF);
        preload(4'd7, 16'h0001);
        accept_instr(8'h06, 4'd6, 4'd7, 8'h00);
        tick();
        tick();
        chk("addu_wdata", rf_wdata, 16'h0000);
        chk("addu_psr_c", 16'(psr[3]), 16'd1);
        chk("addu_psr", 16'(psr), 16'h0018);
        tick();

        // Undefined 0xF0 with instr_valid held through the busy period
        preload(4'd12, 16'h1234);
        preload(4'd13, 16'h0005);
        preload(4'd8, 16'h0001);
        preload(4'd9, 16'h0001);
        instr_valid = 1'b1;
        opcode      = 8'hF0;
        rdest       = 4'd12;
        rsrc        = 4'd13;
        imm         = 8'h00;
        tick();
        chk("undef_busy_ready", 16'(instr_ready), 16'd0);
        opcode = 8'h05;
        rdest  = 4'd14;
        tick();
        chk("undef_alu_op", 16'(alu_opcode), 16'h0000);
        chk("undef_raddr_a", 16'(rf_raddr_a), 16'd12);
        tick();
        chk("undef_done", 16'(done), 16'd1);
        chk("undef_we", 16'(rf_we), 16'd0);
        chk("undef_psr", 16'(psr), 16'h0018);
        opcode = 8'h07;
        rdest  = 4'd8;
        rsrc   = 4'd9;
        tick();
        chk("undef_t4_ready", 16'(instr_ready), 16'd1);
        chk("undef_t4_done", 16'(done), 16'd0);
        tick();
        instr_valid = 1'b0;
        chk("next_raddr_a", 16'(rf_raddr_a), 16'd8);
        chk("next_raddr_b", 16'(rf_raddr_b), 16'd9);
        chk("undef_r12", regs[12], 16'h1234);

        // ADDC uses the carry left by ADDU
        tick();
        chk("addc_cin", 16'(alu_cin), 16'd1);
        chk("addc_alu_a", alu_a, 16'h0001);
        chk("addc_alu_b", alu_b, 16'h0001);
        tick();
        chk("addc_we", 16'(rf_we), 16'd1);
        chk("addc_waddr", 16'(rf_waddr), 16'd8);
        chk("addc_wdata", rf_wdata, 16'h0003);
        chk("addc_psr", 16'(psr), 16'h0000);
        tick();
        chk("addc_r8", regs[8], 16'h0003);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, 16, datapath width.
REQ-002 SHALL have parameter RADDR_W, 4, register-file address width (16 registers).
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports instr_valid in 1 / instr_ready out 1  instruction handshake.
REQ-006 SHALL have ports opcode in 8, rdest in RADDR_W, rsrc in RADDR_W, imm in 8  instruction fields.
REQ-007 SHALL have ports rf_raddr_a out RADDR_W, rf_raddr_b out RADDR_W  register-file read addresses (A=rdest, B=rsrc).
REQ-008 SHALL have ports rf_rdata_a in DATA_W, rf_rdata_b in DATA_W  read data; valid one cycle after address.
REQ-009 SHALL have ports rf_we out 1, rf_waddr out RADDR_W, rf_wdata out DATA_W  writeback.
REQ-010 SHALL have ports alu_a out DATA_W, alu_b out DATA_W, alu_opcode out 8, alu_cin out 1  ALU drive.
REQ-011 SHALL have ports alu_c in DATA_W, alu_flags in 5  ALU result, flags ZCFNL (4=Z,3=C,2=F,1=N,0=L).
REQ-012 SHALL have ports psr out 5  architectural flag register; done out 1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> READ -> EXEC -> WB -> IDLE; instr_ready=1 only in IDLE.
REQ-014 SHALL accept when instr_valid&instr_ready in IDLE (cycle T), latching opcode, rdest, rsrc, imm.
REQ-015 SHALL drive rf_raddr_a=rdest, rf_raddr_b=rsrc from latched fields in READ (T+1).
REQ-016 SHALL in EXEC (T+2) drive alu_a=rf_rdata_a, alu_b=rf_rdata_b or extended imm, alu_cin=psr[3]; capture alu_c into result register at end of EXEC.
REQ-017 SHALL treat opcode[7:4] in {0101,1001,1011} as immediate with imm sign-extended to 16 bits; {0110,0111,1000} as immediate zero-extended; 0000 as register-register.
REQ-018 SHALL remap alu_opcode: 1001xxxx -> 0x09 (SUB), 1011xxxx -> 0x0B (CMP); all other opcodes passed unchanged.
REQ-019 SHALL load psr<=alu_flags at end of EXEC for every valid opcode except NOP (0x00); psr unchanged otherwise.
REQ-020 SHALL in WB (T+3) assert rf_we=1, rf_waddr=rdest, rf_wdata=result, done=1 for exactly one cycle.
REQ-021 SHALL suppress rf_we (done still pulses) for CMP 0x0B, CMPU 0x0F, CMPI 1011xxxx, NOP 0x00, and undefined opcodes.
REQ-022 SHALL treat undefined opcodes (hi nibble not in {0000,0101,0110,0111,1000,1001,1011}, or 0000 with lo nibble 1010/1100/1101/1110) as NOP.
REQ-023 SHALL give fixed latency accept-to-done of 3 cycles; throughput one instruction per 4 cycles; next accept no earlier than T+4.
REQ-024 SHALL ignore instr_valid outside IDLE; fields presented while busy are not latched.
REQ-025 SHALL hold alu_a, alu_b, alu_cin at 0 outside EXEC; alu_opcode=0x00 outside EXEC.

Reset
REQ-026 SHALL on reset: state=IDLE, instr_ready=1, rf_we=0, done=0, psr=5'b00000, rf_raddr_*=0, result=0.
REQ-027 SHALL on reset asserted in any state abort the instruction with no writeback and no psr update.

Structure
REQ-028 SHALL place opcode constants, opcode-class encodings, FSM state enum and flag bit indices in shared package alu_pkg.
REQ-029 SHALL use one combinational sub-module alu_opmap decoding opcode into {alu_opcode, imm_sel, sign_ext, wb_en, flag_en}.

Verification
REQ-030 SHALL cover: R1=0x7FFF, R2=0x0001, ADD 0x05 rdest=1 rsrc=2 -> T+3 rf_we, R1<=0x8000, psr=5'b00100.
REQ-031 SHALL cover: R3=0x0005, ADDI 0x50 imm=0xFF -> alu_b=0xFFFF, R3<=0x0004.
REQ-032 SHALL cover: R4=0x0003, R5=0x0005, CMP 0x0B -> rf_we stays 0, done pulses, psr=5'b00011.
REQ-033 SHALL cover: ADDU 0xFFFF+0x0001 -> result 0, psr[3]=1; then ADDC 0x07 0x0001+0x0001 -> alu_cin=1, result 0x0003.
REQ-034 SHALL cover: reset asserted during EXEC -> no rf_we, psr=0, instr_ready=1 next cycle.
REQ-035 SHALL cover: instr_valid held high through busy period with opcode 0xF0 -> single accept, done at T+3, no write, psr unchanged, next accept at T+4.
